// File: rtl/addsub_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : addsub_digit_serial
// Purpose  : Digit-serial adder/subtractor. It adds or subtracts one
//            DIGIT-bit slice per cycle, least-significant slice first, with
//            valid/ready handshakes on both the operand and result sides.
//            The result takes WIDTH/DIGIT cycles after the operands are
//            accepted.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready  - operand handshake (a, b, m)
//            m                  - 0: a+b, 1: a-b (b inverted, carry-in 1)
//            out_valid/out_ready- result handshake (s, c_out, v, z)
//            c_out              - carry out of MSB (subtract: 1 = no borrow)
//            v                  - signed overflow, z - result is zero
// Options  : `define ADDSUB_SAT_EN to saturate s on signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output logic             z
);

  localparam int            NDIG     = WIDTH / DIGIT;
  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             m_q, m_d, carry_q, carry_d;
  logic             c_out_q, c_out_d, v_q, v_d, z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] w_a_sl, w_b_sl;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_full, w_s_final;
  logic             w_cin_msb, w_v;

  // Slice datapath: one DIGIT-bit ripple add per cycle.
  always_comb begin
    w_a_sl     = a_q[cnt_q*DIGIT +: DIGIT];
    w_b_sl     = b_q[cnt_q*DIGIT +: DIGIT] ^ {DIGIT{m_q}};
    w_sum      = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, carry_q};
    w_res_full = res_q;
    w_res_full[cnt_q*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
    // Carry into the MSB is recovered from the MSB sum bit and its operand
    // bits, so this works for any DIGIT (including DIGIT = 1).
    w_cin_msb  = w_res_full[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ m_q;
    w_v        = w_cin_msb ^ w_sum[DIGIT];
`ifdef ADDSUB_SAT_EN
    // The overflowed result's true sign always matches operand A's sign.
    if (w_v) begin
      w_s_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_s_final = w_res_full;
    end
`else
    w_s_final = w_res_full;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          carry_d = m;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = w_res_full;
        carry_d = w_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          cnt_d   = '0;
          s_d     = w_s_final;
          c_out_d = w_sum[DIGIT];
          v_d     = w_v;
          z_d     = (w_s_final == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  // in_ready is held low while reset is asserted so every output reads 0.
  assign in_ready  = (state_q == IDLE) & rst_n;
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_digit_serial
// Purpose  : Scoreboard bench for addsub_digit_serial. Instance 0 uses
//            WIDTH=16/DIGIT=4 (directed cases, stall, reset abort, random);
//            instance 1 uses WIDTH=16/DIGIT=16 (random back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_digit_serial;

  localparam int W  = 16;
  localparam int D0 = 4;
  localparam int N0 = W / D0;
  localparam int D1 = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic         rst_n0, in_valid0, in_ready0, m0, out_valid0, out_ready0;
  logic [W-1:0] a0, b0, s0;
  logic         c_out0, v0, z0;
  logic         rst_n1, in_valid1, in_ready1, m1, out_valid1, out_ready1;
  logic [W-1:0] a1, b1, s1;
  logic         c_out1, v1, z1;

  res_t         q0[$];
  res_t         q1[$];
  logic [W-1:0] prev_s0 = '0;
  bit           done0 = 1'b0;
  bit           done1 = 1'b0;
  bit           rr_en0 = 1'b0;

  addsub_digit_serial #(.WIDTH(W), .DIGIT(D0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .m(m0), .out_valid(out_valid0), .out_ready(out_ready0),
    .s(s0), .c_out(c_out0), .v(v0), .z(z0)
  );

  addsub_digit_serial #(.WIDTH(W), .DIGIT(D1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .m(m1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .c_out(c_out1), .v(v1), .z(z1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
    res_t r;
    int   sa, sb, sr, ua, ub;
    sa  = int'($signed(ia));
    sb  = int'($signed(ib));
    ua  = int'(ia);
    ub  = int'(ib);
    sr  = im ? (sa - sb) : (sa + sb);
    r.s = W'(sr);
    r.c = im ? (ua >= ub) : ((ua + ub) > 65535);
    r.v = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (r.v) r.s = ia[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    r.z = (r.s == '0);
    return r;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon0
    res_t e;
    if (out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected out_valid", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("dut0 result {s,c,v,z}", 32'({s0, c_out0, v0, z0}), 32'(e));
        prev_s0 = e.s;
      end
    end
  end

  always @(negedge clk) begin : mon1
    res_t e;
    if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected out_valid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1 result {s,c,v,z}", 32'({s1, c_out1, v1, z1}), 32'(e));
      end
    end
  end

  // random consumer back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en0) out_ready0 = ($urandom % 4) != 0;
      if (rst_n1 === 1'b1) out_ready1 = ($urandom % 3) != 0;
    end
  end

  // ---------------- DUT0 stimulus ----------------
  task automatic issue0(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
    int w;
    @(negedge clk);
    a0 = ia; b0 = ib; m0 = im; in_valid0 = 1'b1;
    w = 0;
    while (in_ready0 !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("dut0 accept timeout", 32'd0, 32'd1);
    else q0.push_back(model(ia, ib, im));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); m0 = 1'($urandom);
  endtask

  // Issue, then check latency and that outputs hold the previous result while running.
  task automatic do_op0(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im, input bit junk);
    int cyc;
    bit seen;
    issue0(ia, ib, im);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < N0 + 5) begin
      if (junk) begin
        in_valid0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); m0 = 1'($urandom);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid0 === 1'b1) seen = 1'b1;
      else begin
        chk("dut0 s held while RUN", 32'(s0), 32'(prev_s0));
        chk("dut0 in_ready low in RUN", 32'(in_ready0), 32'd0);
      end
    end
    chk("dut0 latency", 32'(cyc), 32'(N0));
  endtask

  initial begin : drv0
    logic [W-1:0] held;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; m0 = 1'b0; out_ready0 = 1'b0;
    rst_n0 = 1'b1;
    #2 rst_n0 = 1'b0;
    #1 chk("dut0 outputs in reset", 32'({in_ready0, out_valid0, s0, c_out0, v0, z0}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n0 = 1'b1;
    @(negedge clk);
    chk("dut0 in_ready after reset", 32'(in_ready0), 32'd1);
    out_ready0 = 1'b1;

    do_op0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op0(16'h0005, 16'h0003, 1'b1, 1'b0);
    do_op0(16'h0003, 16'h0005, 1'b1, 1'b0);
    do_op0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op0(16'h8000, 16'h0001, 1'b1, 1'b0);

    // Stall in DONE with junk in_valid pulses during RUN and DONE.
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    do_op0(16'h0005, 16'h0003, 1'b1, 1'b1);
    held = s0;
    repeat (3) begin
      in_valid0 = 1'b1; a0 = W'($urandom);
      @(negedge clk);
      chk("dut0 out_valid held", 32'(out_valid0), 32'd1);
      chk("dut0 s held in DONE", 32'(s0), 32'(held));
      chk("dut0 in_ready low in DONE", 32'(in_ready0), 32'd0);
    end
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("dut0 back to IDLE", 32'({in_ready0, out_valid0}), 32'b10);

    // Reset in the middle of RUN, two slices in.
    issue0(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n0 = 1'b0;
    #1 chk("dut0 outputs on mid-RUN reset", 32'({in_ready0, out_valid0, s0, c_out0, v0, z0}), 32'd0);
    q0.delete();
    prev_s0 = '0;
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    @(negedge clk);
    chk("dut0 in_ready after abort", 32'(in_ready0), 32'd1);
    repeat (N0 + 4) begin
      @(negedge clk);
      chk("dut0 no result after abort", 32'(out_valid0), 32'd0);
    end

    rr_en0 = 1'b1;
    for (int i = 0; i < 300; i++) issue0(W'($urandom), W'($urandom), 1'($urandom));
    rr_en0 = 1'b0;
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    done0 = 1'b1;
  end

  // ---------------- DUT1 stimulus ----------------
  task automatic issue1(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
    int w;
    @(negedge clk);
    a1 = ia; b1 = ib; m1 = im; in_valid1 = 1'b1;
    w = 0;
    while (in_ready1 !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("dut1 accept timeout", 32'd0, 32'd1);
    else q1.push_back(model(ia, ib, im));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  initial begin : drv1
    in_valid1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0; out_ready1 = 1'b1;
    rst_n1 = 1'b1;
    #2 rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n1 = 1'b1;
    issue1(16'h7FFF, 16'h0001, 1'b0);
    issue1(16'h8000, 16'h0001, 1'b1);
    for (int i = 0; i < 1000; i++) issue1(W'($urandom), W'($urandom), 1'($urandom));
    done1 = 1'b1;
  end

  // ---------------- end of test ----------------
  initial begin : fin
    int cyc;
    cyc = 0;
    while (!(done0 && done1 && q0.size() == 0 && q1.size() == 0) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 60000) chk("global timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_digit_serial.md
ADDSUB_DIGIT_SERIAL -- requirements
Module: addsub_digit_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port m  input  1  mode: 0 = A+B, 1 = A-B (B inverted, carry-in 1).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port s  output  WIDTH  result.
REQ-013 SHALL have port c_out  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-014 SHALL have port v  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-015 SHALL have port z  output  1  s equals zero.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL, on edge with in_valid & in_ready, latch a, b, m, load carry register with m, clear digit counter, enter RUN.
REQ-019 SHALL ignore a, b, m, in_valid outside IDLE; operands are taken only from latched copies.
REQ-020 SHALL in RUN process one DIGIT-bit slice per cycle, LSB slice first: slice sum = A_slice + (B_slice XOR {DIGIT{m}}) + carry; write slice into result register; update carry.
REQ-021 SHALL capture carry into MSB during the final slice for v computation.
REQ-022 SHALL, at the edge processing slice NDIG-1, enter DONE; out_valid SHALL be high exactly NDIG cycles after the accepting edge.
REQ-023 SHALL hold s, c_out, v, z stable in DONE until out_valid & out_ready; on that edge return to IDLE.
REQ-024 SHALL keep s, c_out, v, z at last completed result while IDLE/RUN (updated only on entry to DONE); in_ready SHALL not assert in the DONE-exit cycle (no same-cycle reaccept).
REQ-025 SHALL compute z from final s (after saturation when enabled).
REQ-026 SHALL produce modulo-2^WIDTH wrap-around results when saturation is not compiled in.
REQ-027 SHALL support NDIG = 1 (DIGIT = WIDTH): single RUN cycle, latency 1.

Reset
REQ-028 SHALL on rst_n low immediately force state IDLE, in_ready = 1 after release, out_valid = 0, s = 0, c_out = 0, v = 0, z = 0, counter and carry = 0.
REQ-029 SHALL abort any RUN/DONE operation on reset; no result from an aborted operation SHALL ever appear.

Configuration
REQ-030 SHALL, with macro ADDSUB_SAT_EN defined, replace s on v = 1 with signed saturation: latched A MSB = 0 -> 0111..1, A MSB = 1 -> 1000..0; v, c_out still report raw overflow/carry.
REQ-031 SHALL, without ADDSUB_SAT_EN, output the raw wrapped result; no saturation logic present.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-032 SHALL cover: m=0, A=0x7FFF, B=0x0001 -> after 4 cycles s=0x8000, v=1, c_out=0, z=0 (ADDSUB_SAT_EN: s=0x7FFF).
REQ-033 SHALL cover: m=1, A=0x0005, B=0x0003 -> s=0x0002, c_out=1, v=0; then A=0x0003, B=0x0005 -> s=0xFFFE, c_out=0, v=0.
REQ-034 SHALL cover: m=0, A=0xFFFF, B=0x0001 -> s=0x0000, c_out=1, v=0, z=1; m=1, A=0x8000, B=0x0001 -> s=0x7FFF, v=1 (sat: 0x8000).
REQ-035 SHALL cover: out_ready low 3 cycles in DONE -> out_valid, s held constant, in_ready=0; in_valid pulses during RUN/DONE ignored.
REQ-036 SHALL cover: rst_n low at digit 2 of RUN -> all outputs 0 immediately, in_ready=1 after release, no out_valid for aborted op.
REQ-037 SHALL cover: DIGIT=16 and random back-to-back ops (1000 vectors, both modes) against reference model.
